pcd8544_spi_rx: RTL and testbench
=================================

Name: pcd8544_spi_rx

Overview:
- Receive-side counterpart of the LCD draw path: an SPI responder that decodes the PCD8544-style serial stream (rst_lcd, sce, dc, mosi, sck) exactly as the panel would.
- Captures bytes, executes the controller command set and emits write strobes into an 84x6-byte display-RAM image.
- Used as an in-system monitor and as the verification model for screen drawing.

Parameters:
- COLS, 84, number of X addresses (columns).
- ROWS, 6, number of Y addresses (8-pixel banks).
- SYNC_STAGES, 2, synchronizer flops on sck/sce/dc/mosi/rst_lcd inputs (min 2).

Ports:
- clk  input  1  system clock; must be >= 4x sck frequency.
- rst_n  input  1  asynchronous active-low reset.
- rst_lcd  input  1  panel reset from driver, active-low, asynchronous to clk.
- sce  input  1  chip enable, active-low.
- dc  input  1  1 = data byte, 0 = command byte; sampled with bit 0 (8th bit).
- mosi  input  1  serial data, MSB first, sampled on sck rising edge.
- sck  input  1  serial clock.
- byte_valid  output  1  one-cycle strobe per completed byte.
- byte_data  output  8  last completed byte.
- byte_dc  output  1  dc captured with byte_data.
- wr_en  output  1  one-cycle display-RAM write strobe.
- wr_addr  output  9  y*COLS + x of the write.
- wr_data  output  8  data written.
- x_addr  output  7  current X pointer.
- y_addr  output  3  current Y pointer.
- pd  output  1  power-down bit.
- v_mode  output  1  0 = horizontal, 1 = vertical addressing.
- h_mode  output  1  extended instruction set select.
- disp_mode  output  2  {D,E} from display-control command.
- vop  output  7  contrast value from extended set.
- frame_done  output  1  one-cycle pulse when the pointer wraps to (0,0) after a data write.

Behaviour:
- Inputs pass through SYNC_STAGES flops. sck rise is detected from the last two synchronized samples.
- rst_n low (async), or synchronized rst_lcd low (sync, same effect):
  - bit counter = 0, FSM = IDLE;
  - x_addr = 0, y_addr = 0, pd = 1, v_mode = 0, h_mode = 0, disp_mode = 00, vop = 0;
  - all strobes = 0, byte_data = 0, byte_dc = 0, wr_addr = 0, wr_data = 0.
- FSM:
  - IDLE: sce high; counter held at 0. sce low -> SHIFT.
  - SHIFT: each sck rise shifts mosi into an 8-bit register and increments the counter. On the 8th rise, latch dc and go to EXEC. sce high with counter 1..7 -> discard partial byte, go to IDLE.
  - EXEC: one cycle. Pulse byte_valid and execute the byte. Then go to SHIFT if sce is low, else IDLE.
- An 8th edge sampled in the same cycle that sce rise is seen completes the byte (edge has priority).
- Latency: byte_valid and wr_en assert exactly SYNC_STAGES+2 clk cycles after the 8th sck rise at the pin.
- Command decode (dc = 0):
  - 0000_0000: nop.
  - 0010_0PVH: pd = P, v_mode = V, h_mode = H (valid in either set).
  - H = 0, 0000_1D0E: disp_mode = {D,E}.
  - H = 0, 0100_0yyy: y_addr = yyy; ignored if yyy >= ROWS.
  - H = 0, 1xxx_xxxx: x_addr = x; ignored if x >= COLS.
  - H = 1, 1vvv_vvvv: vop = v.
  - All other H = 1 commands are ignored.
- Data byte (dc = 1):
  - wr_en pulses with wr_addr = y*COLS + x and wr_data = byte.
  - Pointer then advances in the same EXEC cycle.
- Horizontal addressing (v_mode = 0): x++. At x = COLS-1, x = 0 and y++. At y = ROWS-1 as well, y = 0 and frame_done pulses.
- Vertical addressing (v_mode = 1): y++. At y = ROWS-1, y = 0 and x++. At x = COLS-1 as well, x = 0 and frame_done pulses.
- Data bytes are written even when pd = 1. The pointer behaves identically.

Optional Feature:
- Macro: PCD8544_RX_ERR_EN.
- When defined, add output err (1 bit, sticky, cleared only by reset) and output err_code (2 bits, last cause):
  - 01 = partial byte aborted by sce;
  - 10 = out-of-range set-X/Y;
  - 11 = undefined H = 1 command.
- When not defined, these ports are absent and all such events are silently ignored as described above.

Test Plan:
- Reset defaults: after rst_n release, check x_addr = 0, y_addr = 0, pd = 1, v_mode = 0, disp_mode = 00, all strobes 0. Mid-byte rst_lcd pulse clears the counter; the next full byte decodes correctly.
- Command 0x20, 0x0C, 0x45, 0x8A, then data 0xA5 -> disp_mode = 10, wr_addr = 5*84+10 = 430, wr_data = 0xA5; then x_addr = 11, y_addr = 5.
- Horizontal wrap: set X = 83, Y = 5, send data 0xFF -> wr_addr = 503, frame_done pulse, pointer (0,0). Then 504 data bytes from (0,0) -> exactly one more frame_done.
- Vertical mode: 0x22, set X = 0, Y = 5, send 2 bytes -> wr_addr = 420 then 1; pointer ends at (1,1).
- Abort: sce high after 5 bits, then full byte 0x3C with dc = 1 -> only one byte_valid, byte_data = 0x3C. With PCD8544_RX_ERR_EN, err = 1 and err_code = 01.
- Extended set: 0x21, 0xBF, 0x20, then 0xFF as command -> vop = 0x3F. Set-X 127 is ignored, x_addr unchanged.

Source files
------------

// File: rtl/pcd8544_spi_rx.sv
// PCD8544-style SPI responder: decodes the serial panel stream into commands and display-RAM writes.
// Define PCD8544_RX_ERR_EN to add the sticky err / err_code diagnostic outputs.
module pcd8544_spi_rx #(
  parameter int unsigned COLS        = 84,
  parameter int unsigned ROWS        = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rst_lcd,
  input  logic       sce,
  input  logic       dc,
  input  logic       mosi,
  input  logic       sck,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       wr_en,
  output logic [8:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [6:0] x_addr,
  output logic [2:0] y_addr,
  output logic       pd,
  output logic       v_mode,
  output logic       h_mode,
  output logic [1:0] disp_mode,
  output logic [6:0] vop,
  output logic       frame_done
`ifdef PCD8544_RX_ERR_EN
  ,
  output logic       err,
  output logic [1:0] err_code
`endif
);

  localparam int unsigned      SIG_W     = 5;
  localparam logic [SIG_W-1:0] SYNC_IDLE = 5'b11000;
  localparam logic [6:0]       X_LAST    = 7'(COLS - 1);
  localparam logic [2:0]       Y_LAST    = 3'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, EXEC} state_e;

  // Synchronizer chain for {rst_lcd, sce, dc, mosi, sck}, reset to idle bus levels
  logic [SIG_W-1:0] sync_q [SYNC_STAGES];
  logic             sck_d;
  logic             rst_lcd_s, sce_s, dc_s, mosi_s, sck_s, sck_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= SYNC_IDLE;
      sck_d <= 1'b0;
    end else begin
      sync_q[0] <= {rst_lcd, sce, dc, mosi, sck};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      sck_d <= sck_s;
    end
  end

  assign {rst_lcd_s, sce_s, dc_s, mosi_s, sck_s} = sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       dc_lat_q, dc_lat_d;
  logic       byte_valid_d, byte_dc_d, wr_en_d, frame_done_d;
  logic [7:0] byte_data_d, wr_data_d;
  logic [8:0] wr_addr_d;
  logic [6:0] x_d, vop_d;
  logic [2:0] y_d;
  logic       pd_d, v_d, h_d;
  logic [1:0] disp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      shreg_q    <= 8'd0;
      dc_lat_q   <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      byte_dc    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= 9'd0;
      wr_data    <= 8'd0;
      x_addr     <= 7'd0;
      y_addr     <= 3'd0;
      pd         <= 1'b1;
      v_mode     <= 1'b0;
      h_mode     <= 1'b0;
      disp_mode  <= 2'b00;
      vop        <= 7'd0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      dc_lat_q   <= dc_lat_d;
      byte_valid <= byte_valid_d;
      byte_data  <= byte_data_d;
      byte_dc    <= byte_dc_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      x_addr     <= x_d;
      y_addr     <= y_d;
      pd         <= pd_d;
      v_mode     <= v_d;
      h_mode     <= h_d;
      disp_mode  <= disp_d;
      vop        <= vop_d;
      frame_done <= frame_done_d;
    end
  end

  // Next-state and output decode; panel reset acts as a synchronous clear
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    dc_lat_d     = dc_lat_q;
    byte_valid_d = 1'b0;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;
    byte_data_d  = byte_data;
    byte_dc_d    = byte_dc;
    wr_addr_d    = wr_addr;
    wr_data_d    = wr_data;
    x_d          = x_addr;
    y_d          = y_addr;
    pd_d         = pd;
    v_d          = v_mode;
    h_d          = h_mode;
    disp_d       = disp_mode;
    vop_d        = vop;

    if (!rst_lcd_s) begin
      state_d     = IDLE;
      cnt_d       = 3'd0;
      byte_data_d = 8'd0;
      byte_dc_d   = 1'b0;
      wr_addr_d   = 9'd0;
      wr_data_d   = 8'd0;
      x_d         = 7'd0;
      y_d         = 3'd0;
      pd_d        = 1'b1;
      v_d         = 1'b0;
      h_d         = 1'b0;
      disp_d      = 2'b00;
      vop_d       = 7'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = 3'd0;
          if (!sce_s) state_d = SHIFT;
        end
        SHIFT: begin
          // A completing edge wins over a simultaneous chip-enable release
          if (sck_rise) begin
            shreg_d = {shreg_q[6:0], mosi_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              dc_lat_d = dc_s;
              state_d  = EXEC;
            end
          end else if (sce_s) begin
            cnt_d   = 3'd0;
            state_d = IDLE;
          end
        end
        EXEC: begin
          state_d      = sce_s ? IDLE : SHIFT;
          byte_valid_d = 1'b1;
          byte_data_d  = shreg_q;
          byte_dc_d    = dc_lat_q;
          if (dc_lat_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = 9'(32'(y_addr) * COLS + 32'(x_addr));
            wr_data_d = shreg_q;
            if (!v_mode) begin
              if (x_addr == X_LAST) begin
                x_d = 7'd0;
                if (y_addr == Y_LAST) begin
                  y_d          = 3'd0;
                  frame_done_d = 1'b1;
                end else begin
                  y_d = y_addr + 3'd1;
                end
              end else begin
                x_d = x_addr + 7'd1;
              end
            end else begin
              if (y_addr == Y_LAST) begin
                y_d = 3'd0;
                if (x_addr == X_LAST) begin
                  x_d          = 7'd0;
                  frame_done_d = 1'b1;
                end else begin
                  x_d = x_addr + 7'd1;
                end
              end else begin
                y_d = y_addr + 3'd1;
              end
            end
          end else if (shreg_q[7:3] == 5'b00100) begin
            {pd_d, v_d, h_d} = shreg_q[2:0];
          end else if (!h_mode) begin
            if (shreg_q[7:3] == 5'b00001 && !shreg_q[1])
              disp_d = {shreg_q[2], shreg_q[0]};
            else if (shreg_q[7:3] == 5'b01000 && 32'(shreg_q[2:0]) < ROWS)
              y_d = shreg_q[2:0];
            else if (shreg_q[7] && 32'(shreg_q[6:0]) < COLS)
              x_d = shreg_q[6:0];
          end else if (shreg_q[7]) begin
            vop_d = shreg_q[6:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PCD8544_RX_ERR_EN
  logic abort_ev, range_ev, undef_ev;

  // Error causes observed from the same state as the main decoder
  always_comb begin
    abort_ev = rst_lcd_s && state_q == SHIFT && !sck_rise && sce_s && cnt_q != 3'd0;
    range_ev = rst_lcd_s && state_q == EXEC && !dc_lat_q && !h_mode &&
               ((shreg_q[7:3] == 5'b01000 && 32'(shreg_q[2:0]) >= ROWS) ||
                (shreg_q[7] && 32'(shreg_q[6:0]) >= COLS));
    undef_ev = rst_lcd_s && state_q == EXEC && !dc_lat_q && h_mode && !shreg_q[7] &&
               shreg_q != 8'h00 && shreg_q[7:3] != 5'b00100;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_code <= 2'b00;
    end else if (!rst_lcd_s) begin
      err      <= 1'b0;
      err_code <= 2'b00;
    end else if (abort_ev) begin
      err      <= 1'b1;
      err_code <= 2'b01;
    end else if (range_ev) begin
      err      <= 1'b1;
      err_code <= 2'b10;
    end else if (undef_ev) begin
      err      <= 1'b1;
      err_code <= 2'b11;
    end
  end
`endif

endmodule

// File: tb/tb_pcd8544_spi_rx.sv
// Scoreboard bench for pcd8544_spi_rx: directed SPI frames, expected bytes/writes queued at issue time.
module tb_pcd8544_spi_rx;

  localparam int unsigned SYNC = 2;
  localparam int          HALF = 3;

  logic       clk = 1'b0;
  logic       rst_n, rst_lcd, sce, dc, mosi, sck;
  logic       byte_valid, byte_dc, wr_en, pd, v_mode, h_mode, frame_done;
  logic [7:0] byte_data, wr_data;
  logic [8:0] wr_addr;
  logic [6:0] x_addr, vop;
  logic [2:0] y_addr;
  logic [1:0] disp_mode;
`ifdef PCD8544_RX_ERR_EN
  logic       err;
  logic [1:0] err_code;
`endif

  pcd8544_spi_rx #(.COLS(84), .ROWS(6), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .rst_lcd(rst_lcd), .sce(sce), .dc(dc), .mosi(mosi), .sck(sck),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .x_addr(x_addr), .y_addr(y_addr), .pd(pd), .v_mode(v_mode), .h_mode(h_mode),
    .disp_mode(disp_mode), .vop(vop), .frame_done(frame_done)
`ifdef PCD8544_RX_ERR_EN
    , .err(err), .err_code(err_code)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic [8:0] addr;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_rise = 0;
  int   fd_cnt = 0;
  int   fd_base;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endfunction

  // Monitor: pop one expectation per byte_valid; flag strobes outside a byte
  always @(negedge clk) begin
    exp_t e;
    if (frame_done) fd_cnt++;
    if (byte_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_byte: got byte 0x%0h required none", byte_data);
      end else begin
        e = exp_q.pop_front();
        chk("byte_data", 32'(byte_data), 32'(e.data));
        chk("byte_dc", 32'(byte_dc), 32'(e.dc));
        chk("wr_en", 32'(wr_en), 32'(e.dc));
        if (e.dc) begin
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", 32'(wr_data), 32'(e.data));
        end
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        chk("latency", 32'(cyc - last_rise), 32'(SYNC + 2));
      end
    end else if (wr_en || frame_done) begin
      checks++;
      errors++;
      $display("FAIL stray_strobe: got wr_en %0b frame_done %0b required 0 0", wr_en, frame_done);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      dc   = d;
      tick(HALF);
      sck = 1'b1;
      if (i == 7) last_rise = cyc;
      tick(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    sce = 1'b0;
    tick(2);
    send_bits(b, d, 8);
    tick(HALF);
    sce = 1'b1;
    tick(2);
  endtask

  task automatic cmd(input logic [7:0] b);
    exp_q.push_back('{b, 1'b0, 9'd0, 1'b0});
    send_byte(b, 1'b0);
  endtask

  task automatic dat(input logic [7:0] b, input logic [8:0] a, input logic f);
    exp_q.push_back('{b, 1'b1, a, f});
    send_byte(b, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending bytes required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rst_lcd = 1'b1; sce = 1'b1; dc = 1'b0; mosi = 1'b0; sck = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(5);
    chk("rst_x", 32'(x_addr), 32'd0);
    chk("rst_y", 32'(y_addr), 32'd0);
    chk("rst_pd", 32'(pd), 32'd1);
    chk("rst_v", 32'(v_mode), 32'd0);
    chk("rst_h", 32'(h_mode), 32'd0);
    chk("rst_disp", 32'(disp_mode), 32'd0);
    chk("rst_vop", 32'(vop), 32'd0);
    chk("rst_strobes", 32'({byte_valid, wr_en, frame_done}), 32'd0);
`ifdef PCD8544_RX_ERR_EN
    chk("rst_err", 32'({err, err_code}), 32'd0);
`endif

    // Panel reset in the middle of a byte, then a clean byte in the same frame
    sce = 1'b0;
    tick(2);
    send_bits(8'hF0, 1'b0, 4);
    rst_lcd = 1'b0;
    tick(6);
    rst_lcd = 1'b1;
    tick(6);
    exp_q.push_back('{8'h0C, 1'b0, 9'd0, 1'b0});
    send_bits(8'h0C, 1'b0, 8);
    tick(HALF);
    sce = 1'b1;
    tick(2);
    drain();
    chk("lcdrst_disp", 32'(disp_mode), 32'd2);
    chk("lcdrst_pd", 32'(pd), 32'd1);

    // Basic command set and a single write at (10,5)
    cmd(8'h20); cmd(8'h0C); cmd(8'h45); cmd(8'h8A);
    dat(8'hA5, 9'd430, 1'b0);
    drain();
    chk("basic_disp", 32'(disp_mode), 32'd2);
    chk("basic_pd", 32'(pd), 32'd0);
    chk("basic_x", 32'(x_addr), 32'd11);
    chk("basic_y", 32'(y_addr), 32'd5);

    // Horizontal wrap from the last cell
    cmd(8'hD3); cmd(8'h45);
    dat(8'hFF, 9'd503, 1'b1);
    drain();
    chk("hwrap_x", 32'(x_addr), 32'd0);
    chk("hwrap_y", 32'(y_addr), 32'd0);

    // One full frame of data
    fd_base = fd_cnt;
    for (int i = 0; i < 504; i++) dat(8'(i), 9'(i), i == 503);
    drain();
    chk("frame_count", 32'(fd_cnt - fd_base), 32'd1);
    chk("frame_x", 32'(x_addr), 32'd0);
    chk("frame_y", 32'(y_addr), 32'd0);

    // Vertical addressing across the bottom bank
    cmd(8'h22); cmd(8'h80); cmd(8'h45);
    dat(8'h11, 9'd420, 1'b0);
    dat(8'h22, 9'd1, 1'b0);
    drain();
    chk("vert_mode", 32'(v_mode), 32'd1);
    chk("vert_x", 32'(x_addr), 32'd1);
    chk("vert_y", 32'(y_addr), 32'd1);

    // Partial byte aborted by sce, then a full data byte at (1,1)
    cmd(8'h20);
    sce = 1'b0;
    tick(2);
    send_bits(8'hA5, 1'b1, 5);
    tick(HALF);
    sce = 1'b1;
    tick(6);
    dat(8'h3C, 9'd85, 1'b0);
    drain();
    chk("abort_x", 32'(x_addr), 32'd2);
    chk("abort_y", 32'(y_addr), 32'd1);
`ifdef PCD8544_RX_ERR_EN
    chk("abort_err", 32'({err, err_code}), 32'b101);
`endif

    // Out-of-range Y, extended set contrast, undefined extended command, out-of-range X
    cmd(8'h46);
    drain();
    chk("bady_y", 32'(y_addr), 32'd1);
`ifdef PCD8544_RX_ERR_EN
    chk("bady_err", 32'({err, err_code}), 32'b110);
`endif
    cmd(8'h21); cmd(8'hBF); cmd(8'h04);
    drain();
    chk("ext_h", 32'(h_mode), 32'd1);
    chk("ext_vop", 32'(vop), 32'h3F);
`ifdef PCD8544_RX_ERR_EN
    chk("undef_err", 32'({err, err_code}), 32'b111);
`endif
    cmd(8'h20); cmd(8'hFF);
    drain();
    chk("badx_x", 32'(x_addr), 32'd2);
    chk("badx_h", 32'(h_mode), 32'd0);
    chk("badx_vop", 32'(vop), 32'h3F);
`ifdef PCD8544_RX_ERR_EN
    chk("badx_err", 32'({err, err_code}), 32'b110);
`endif

    tick(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
